muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised multi-cycle integer multiply/divide unit for the MIPS datapath. It supersedes the fixed 32-bit signed-only multiplier and adds unsigned multiply, signed divide and unsigned divide. It has a start/busy/done handshake and divide-by-zero detection. Results go into HI/LO registers that the control unit reads through mfhi/mflo.

Parameters:
WIDTH, 32, operand width in bits. HI and LO are each WIDTH bits. Legal values are even and ≥ 4.
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU
a  in  WIDTH  multiplicand / dividend; sampled with start
b  in  WIDTH  multiplier / divisor; sampled with start
hi  out  WIDTH  MULT*: upper product half; DIV*: remainder
lo  out  WIDTH  MULT*: lower product half; DIV*: quotient
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when hi/lo update
div_zero  out  1  set with done when a DIV/DIVU had b==0; holds until next accepted start

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - An in-flight operation is abandoned and produces no done.
- States:
  - IDLE: start==1 at edge E0 latches a, b, op, moves to RUN, busy=1, div_zero=0, counter=0. start==0 stays in IDLE.
  - RUN: one iteration per edge; counter increments.
  - At edge E(WIDTH): hi/lo written, done=1 for that cycle only, busy=0, return to IDLE.
  - No separate DONE state.
- Latency: exactly WIDTH cycles from the start-accept edge to the done-asserting edge, for every op except divide-by-zero.
- Back-to-back: start asserted in the done cycle is accepted at the next edge.
- start while busy: ignored, with no effect on the operation or the latched operands.
- Mid-operation changes: a, b and op changes during RUN are ignored.
- hi/lo hold their values between completions.
- MULT: signed WIDTH×WIDTH → 2·WIDTH product, two's complement; {hi,lo}=a*b. Radix-2 Booth recoding is the intended implementation.
- MULTU: unsigned product; {hi,lo}=a*b, operands zero-extended.
- DIVU: restoring or non-restoring shift-subtract. lo=floor(a/b), hi=a mod b.
- DIV:
  - Operate on magnitudes.
  - Quotient truncates toward zero; negate it if sign(a)≠sign(b).
  - Remainder takes the sign of a.
  - Identity a == lo*b + hi holds modulo 2^WIDTH.
- Overflow DIV: a=most-negative, b=−1 → lo=most-negative, hi=0, div_zero=0.
- Divide by zero (op[1]==1, b==0):
  - Skip iteration. At edge E1: hi=a, lo=all-ones, div_zero=1, done=1, busy=0.
  - Latency is 1 cycle.
- Multiply with b==0 is normal: full WIDTH-cycle latency, result 0.
- Internal accumulator width: 2·WIDTH+1 bits, no truncation except the final split into hi and lo.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFD(−3), b=7 → done exactly 32 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for those 32 cycles.
2. MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands → hi=0, lo=1.
3. DIV a=0xFFFFFFF9(−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIV a=5, b=0 → done one cycle after accept; div_zero=1, hi=5, lo=0xFFFFFFFF. The next MULT start clears div_zero at its accept edge.
5. Handshake and reset:
   - Start a MULT; pulse start with new operands at cycle 10 → ignored; result matches the original operands.
   - Start again in the done cycle → accepted; done again 32 cycles later.
   - Drop reset at cycle 15 of an op → hi, lo, busy and done go to 0 immediately; no done follows.
6. WIDTH=8:
   - MULT 0x80×0x80 → hi=0x40, lo=0x00, latency 8.
   - DIV 0x81(−127)/0x05 → lo=0xE7(−25), hi=0xFE(−2).

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/busy/done handshake and HI/LO result bus of the multiply/divide unit
//   master: drives start, op, a, b; observes hi, lo, busy, done, div_zero
//   slave : the unit itself, the opposite directions
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO, one iteration per clock
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of muldiv_unit_if
//           start/op/a/b sampled in IDLE; hi/lo results, busy, one-cycle done, sticky div_zero
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int AW = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d, mul_step, div_step;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
    logic [1:0]       op_q, op_d;
    logic             dz_q, dz_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic             done_q, done_d, div_zero_q, div_zero_d;
    logic [WIDTH:0]   m_ext, addend, hi_sum, r_sh, diff;
    logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
    logic             sdiv;

    // Accumulator layout: {upper (WIDTH+1), lower (WIDTH)}.
    // Multiply: upper = partial product, lower = multiplier shifting out.
    // Divide:   upper = partial remainder, lower = dividend in / quotient out.
    always_comb begin
        m_ext    = op_q[0] ? {1'b0, m_q} : {m_q[WIDTH-1], m_q};
        // MULTU adds on a set bit; MULT uses Booth pairs (1,0) subtract, (0,1) add
        addend   = op_q[0] ? (acc_q[0] ? m_ext : '0)
                 : (acc_q[0] == qm1_q) ? '0 : (acc_q[0] ? -m_ext : m_ext);
        hi_sum   = acc_q[AW-1:WIDTH] + addend;
        mul_step = {~op_q[0] & hi_sum[WIDTH], hi_sum, acc_q[WIDTH-1:1]};
        r_sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = r_sh - {1'b0, m_q};
        div_step = diff[WIDTH] ? {r_sh, acc_q[WIDTH-2:0], 1'b0} : {diff, acc_q[WIDTH-2:0], 1'b1};
        quo      = div_step[WIDTH-1:0];
        rem      = div_step[2*WIDTH-1:WIDTH];
        sdiv     = bus.op == 2'b10;
        a_mag    = (sdiv && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag    = (sdiv && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        qm1_d      = qm1_q;
        m_d        = m_q;
        a_d        = a_q;
        op_d       = op_q;
        dz_d       = dz_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d    = RUN;
                cnt_d      = '0;
                op_d       = bus.op;
                a_d        = bus.a;
                dz_d       = bus.op[1] && (bus.b == '0);
                qneg_d     = sdiv && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                rneg_d     = sdiv && bus.a[WIDTH-1];
                m_d        = bus.op[1] ? b_mag : bus.a;
                acc_d      = {{(WIDTH+1){1'b0}}, bus.op[1] ? a_mag : bus.b};
                qm1_d      = 1'b0;
                div_zero_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = op_q[1] ? div_step : mul_step;
            qm1_d = acc_q[0];
            if (dz_q) begin
                state_d    = IDLE;
                hi_d       = a_q;
                lo_d       = '1;
                div_zero_d = 1'b1;
                done_d     = 1'b1;
            end else if (cnt_q == LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = op_q[1] ? (rneg_q ? -rem : rem) : mul_step[2*WIDTH-1:WIDTH];
                lo_d    = op_q[1] ? (qneg_q ? -quo : quo) : mul_step[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            a_q        <= '0;
            op_q       <= '0;
            dz_q       <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            qm1_q      <= qm1_d;
            m_q        <= m_d;
            a_q        <= a_d;
            op_q       <= op_d;
            dz_q       <= dz_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = state_q == RUN;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule
